// File: rtl/id_reg_file_pkg.sv
// Shared pipeline definitions for the decode-stage register file and its helpers.
// Holds the datapath width, the register address width, the register count and
// the index of the hardwired zero register.
package id_reg_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int REG_ZERO = 0;

endpackage : id_reg_file_pkg

// File: rtl/id_reg_file_rf_bypass.sv
// Read-port output select for the register file: zero register forcing and,
// when REGFILE_BYPASS_EN is defined, write-before-read forwarding of the
// write-back data. One instance per read port.
module rf_bypass
  import id_reg_file_pkg::*;
#(
  parameter int DW = id_reg_file_pkg::DATA_W,
  parameter int AW = id_reg_file_pkg::ADDR_W
) (
  input  logic [AW-1:0] readAddr_i,
  input  logic [DW-1:0] storedData_i,
  input  logic          writeEn_i,
  input  logic          rst_i,
  input  logic [AW-1:0] writeAddr_i,
  input  logic [DW-1:0] writeData_i,
  output logic [DW-1:0] readData_o
);

`ifndef REGFILE_BYPASS_EN
  logic unusedBypassInputs;
  assign unusedBypassInputs = ^{writeEn_i, rst_i, writeAddr_i, writeData_i};
`endif

  // Pick stored data, forward in-flight write data if enabled, and pin r0 to zero.
  always_comb begin
    readData_o = storedData_i;
`ifdef REGFILE_BYPASS_EN
    if (writeEn_i && !rst_i && (readAddr_i == writeAddr_i)) begin
      readData_o = writeData_i;
    end
`endif
    if (readAddr_i == AW'(REG_ZERO)) begin
      readData_o = '0;
    end
  end

endmodule : rf_bypass

// File: rtl/id_reg_file.sv
// Decode-stage register file: 2**ADDR_W x DATA_W storage, one write port fed by
// write-back, two combinational read ports, and a count of committed writes.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module id_reg_file
  import id_reg_file_pkg::*;
#(
  parameter int DATA_W = id_reg_file_pkg::DATA_W,
  parameter int ADDR_W = id_reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_RegWrite,
  input  logic [ADDR_W-1:0] RegWriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [31:0]       WriteCount
);

  localparam int Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [31:0]       writeCount_q;
  logic [31:0]       writeCount_d;
  logic              writeCommit;
  logic [DATA_W-1:0] storedData1;
  logic [DATA_W-1:0] storedData2;

  assign writeCommit  = ID_RegWrite && (RegWriteAddr != ADDR_W'(REG_ZERO));
  assign writeCount_d = writeCount_q + 32'd1;
  assign storedData1  = regs_q[ReadAddr1];
  assign storedData2  = regs_q[ReadAddr2];
  assign WriteCount   = writeCount_q;

  // Commit write-back data and count it; reset clears storage and counter and drops any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
      writeCount_q <= '0;
    end else if (writeCommit) begin
      regs_q[RegWriteAddr] <= WriteData;
      writeCount_q         <= writeCount_d;
    end
  end

  rf_bypass #(
    .DW (DATA_W),
    .AW (ADDR_W)
  ) readPort1 (
    .readAddr_i   (ReadAddr1),
    .storedData_i (storedData1),
    .writeEn_i    (ID_RegWrite),
    .rst_i        (rst),
    .writeAddr_i  (RegWriteAddr),
    .writeData_i  (WriteData),
    .readData_o   (ReadData1)
  );

  rf_bypass #(
    .DW (DATA_W),
    .AW (ADDR_W)
  ) readPort2 (
    .readAddr_i   (ReadAddr2),
    .storedData_i (storedData2),
    .writeEn_i    (ID_RegWrite),
    .rst_i        (rst),
    .writeAddr_i  (RegWriteAddr),
    .writeData_i  (WriteData),
    .readData_o   (ReadData2)
  );

endmodule : id_reg_file

// File: tb/tb_id_reg_file.sv
// Self-checking bench for id_reg_file. Expected read data and write count come
// from a small register-file model; they are queued when a cycle's stimulus is
// driven and popped when the combinational outputs are sampled.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_id_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          ID_RegWrite;
  logic [AW-1:0] RegWriteAddr;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] ReadAddr1;
  logic [AW-1:0] ReadAddr2;
  logic [DW-1:0] ReadData1;
  logic [DW-1:0] ReadData2;
  logic [31:0]   WriteCount;

  always #5 clk = ~clk;

  id_reg_file #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ID_RegWrite  (ID_RegWrite),
    .RegWriteAddr (RegWriteAddr),
    .WriteData    (WriteData),
    .ReadAddr1    (ReadAddr1),
    .ReadAddr2    (ReadAddr2),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .WriteCount   (WriteCount)
  );

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expT;

  expT         expQ[$];
  int          checks   = 0;
  int          failures = 0;
  logic [DW-1:0] modelRegs [32];
  logic [31:0]   modelCount;

  // Expected combinational read for the inputs currently being driven.
  function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = modelRegs[a];
`ifdef REGFILE_BYPASS_EN
    if (ID_RegWrite && !rst && (a == RegWriteAddr)) v = WriteData;
`endif
    if (a == '0) v = '0;
    return v;
  endfunction

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle, queue and check the outputs before the edge, then advance the model.
  task automatic applyStimulus(input logic r, input logic we, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic [AW-1:0] a1,
                               input logic [AW-1:0] a2, input string tag);
    expT e;
    rst          = r;
    ID_RegWrite  = we;
    RegWriteAddr = wa;
    WriteData    = wd;
    ReadAddr1    = a1;
    ReadAddr2    = a2;
    #1;
    expQ.push_back('{tag: {tag, "/rd1"}, value: modelRead(a1)});
    expQ.push_back('{tag: {tag, "/rd2"}, value: modelRead(a2)});
    expQ.push_back('{tag: {tag, "/cnt"}, value: modelCount});
    e = expQ.pop_front();
    checkOutput(e.tag, ReadData1, e.value);
    e = expQ.pop_front();
    checkOutput(e.tag, ReadData2, e.value);
    e = expQ.pop_front();
    checkOutput(e.tag, WriteCount, e.value);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) modelRegs[i] = '0;
      modelCount = '0;
    end else if (we && (wa != '0)) begin
      modelRegs[wa] = wd;
      modelCount    = modelCount + 32'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    rst          = 1'b1;
    ID_RegWrite  = 1'b0;
    RegWriteAddr = '0;
    WriteData    = '0;
    ReadAddr1    = '0;
    ReadAddr2    = '0;
    for (int i = 0; i < 32; i++) modelRegs[i] = '0;
    modelCount = '0;

    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, AW'(i), AW'(31 - i), "reset_read");
    end

    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd5, "write_r5");
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "read_r5");

    applyStimulus(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, "write_r0");
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "read_r0");

    applyStimulus(1'b0, 1'b1, 5'd7, 32'h1, 5'd0, 5'd5, "write_r7_1");
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h2, 5'd7, 5'd7, "same_cycle_r7");
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, "next_cycle_r7");

    for (int i = 0; i < 40; i++) begin
      wa = AW'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), wa, DW'($urandom), ra,
                    AW'($urandom_range(0, 31)), "random");
    end

    applyStimulus(1'b1, 1'b1, 5'd9, 32'hAA, 5'd9, 5'd5, "reset_with_write_r9");
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd5, "after_reset_r9");
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd31, "after_reset_r7");

    applyStimulus(1'b0, 1'b1, 5'd12, 32'hCAFEF00D, 5'd0, 5'd0, "write_r12");
    force dut.writeCount_q = 32'hFFFFFFFF;
    #1;
    release dut.writeCount_q;
    modelCount = 32'hFFFFFFFF;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd0, "count_preload");
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h55, 5'd0, 5'd0, "write_r3_wrap");
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd12, "count_wrapped");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_id_reg_file

// File: doc/id_reg_file.md
ID_REG_FILE -- requirements
Module: id_reg_file

Interface
REQ-001 Parameter: DATA_W, default 32, register and data width in bits.
REQ-002 Parameter: ADDR_W, default 5, register address width; depth is 2**ADDR_W (32).
REQ-003 Port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: ID_RegWrite  input  1  write enable from WB stage.
REQ-006 Port: RegWriteAddr  input  ADDR_W  destination register from WB stage.
REQ-007 Port: WriteData  input  DATA_W  write-back data from WB mux.
REQ-008 Port: ReadAddr1  input  ADDR_W  rs address from IF/ID instruction.
REQ-009 Port: ReadAddr2  input  ADDR_W  rt address from IF/ID instruction.
REQ-010 Port: ReadData1  output  DATA_W  rs operand to ID/EX.
REQ-011 Port: ReadData2  output  DATA_W  rt operand to ID/EX.
REQ-012 Port: WriteCount  output  32  count of committed register writes.

Function
REQ-013 The block SHALL be the receiving end of the WB write-back interface: it stores WriteData into register RegWriteAddr on posedge clk when ID_RegWrite=1 and rst=0.
REQ-014 Register 0 SHALL read as 0 on both ports always; writes to address 0 SHALL be discarded.
REQ-015 Read ports SHALL be combinational from ReadAddr1/ReadAddr2 and current register contents (zero-cycle latency).
REQ-016 Both read ports reading the same address SHALL return identical data.
REQ-017 WriteCount SHALL increment by 1 on each posedge where a write commits to a nonzero address; writes to address 0 or with ID_RegWrite=0 SHALL not count.
REQ-018 WriteCount SHALL wrap from 0xFFFFFFFF to 0x00000000.
REQ-019 Unknown or X on ID_RegWrite is out of scope; the block is not required to tolerate it.

Reset
REQ-020 On a posedge with rst=1, all registers and WriteCount SHALL clear to 0.
REQ-021 A write presented in the same cycle as rst=1 SHALL be discarded and not counted.
REQ-022 Reset asserted mid-program SHALL take effect in one cycle; ReadData1/2 SHALL read 0 in the first cycle after the reset edge.

Configuration
REQ-023 Macro REGFILE_BYPASS_EN, when defined, SHALL make a read whose address equals RegWriteAddr, with ID_RegWrite=1, rst=0 and address nonzero, return WriteData combinationally in that same cycle (write-before-read).
REQ-024 Without REGFILE_BYPASS_EN, such a read SHALL return the pre-write stored value; the new value appears from the next cycle.

Structure
REQ-025 DATA_W, ADDR_W, NUM_REGS (32) and REG_ZERO (0) SHALL live in the shared pipeline definitions package/include used by all stage modules.
REQ-026 The per-port bypass/zero-select logic SHALL be one sub-module, rf_bypass, instantiated once per read port.
REQ-027 Storage SHALL be a single 32 x DATA_W array with one write port.

Verification
REQ-028 rst=1 one cycle, then read all 32 addresses -> every ReadData = 0, WriteCount = 0.
REQ-029 Write 0xDEADBEEF to r5, next cycle ReadAddr1=5, ReadAddr2=5 -> both read 0xDEADBEEF; WriteCount = 1.
REQ-030 Write 0x12345678 to r0 -> ReadData for address 0 stays 0, WriteCount unchanged.
REQ-031 r7=0x1, same cycle write r7=0x2 and ReadAddr1=7 -> 0x2 with REGFILE_BYPASS_EN, 0x1 without; 0x2 in both builds next cycle.
REQ-032 Write r9=0xAA with rst=1 in the same cycle -> r9 reads 0, WriteCount = 0.
REQ-033 Force WriteCount to 0xFFFFFFFF (via 2^32-1 writes or a bench backdoor), then one write to r3 -> WriteCount = 0x00000000.
